uart_ctrl: RTL

- Memory-mapped UART controller between the MIPS CPU data bus and the UART TX/RX core.
- Buffers outgoing bytes in a small TX FIFO and sequences the sender's TX_EN/TX_STATUS handshake one byte at a time.
- Captures received bytes on the receiver's RX_STATUS rising edge and exposes them through data, status and control registers.
- Raises an interrupt for the CPU.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART controller: bus register map, CON bit layout
// and the TX sequencer state encoding.
package uart_pkg;

  localparam logic [1:0] ADDR_TXD = 2'd0;
  localparam logic [1:0] ADDR_RXD = 2'd1;
  localparam logic [1:0] ADDR_CON = 2'd2;

  localparam int CON_TX_FULL   = 0;
  localparam int CON_TX_BUSY   = 1;
  localparam int CON_RX_VALID  = 2;
  localparam int CON_RX_OVR    = 3;
  localparam int CON_TX_OVF    = 4;
  localparam int CON_RX_IRQ_EN = 5;
  localparam int CON_TX_IRQ_EN = 6;
  localparam int CON_CNT_LSB   = 7;

  // RETRY is the single low cycle on uart_tx_en after a launch times out.
  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_LAUNCH = 2'd1,
    TX_RETRY  = 2'd2,
    TX_BUSY   = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for outgoing UART data. The head is readable combinationally so a
// pop and the capture of the popped byte happen in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_srst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: TX FIFO plus launch/handshake sequencer,
// RX byte capture with overrun tracking, CON register and interrupt.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int TX_DEPTH      = 4,
  parameter int START_TIMEOUT = 1023
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        irq,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_en,
  input  logic        uart_tx_status,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_status
);

  localparam int CNT_W = $clog2(TX_DEPTH) + 1;
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);

  logic             r_tx_s1, r_tx_s2;
  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_tx_en;
  logic [7:0]       r_tx_data;
  logic [7:0]       r_rx_buf;
  logic             r_rx_valid, r_rx_ovr, r_tx_ovf;
  logic             r_rx_irq_en, r_tx_irq_en, r_irq;

  logic             w_tx_s, w_rx_rise;
  logic             w_txd_wr, w_rxd_rd, w_con_wr;
  logic             w_pop, w_full, w_empty, w_tx_busy;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_con;
  logic             w_unused;

  assign w_tx_s    = r_tx_s2;
  assign w_rx_rise = r_rx_s2 & ~r_rx_s3;
  assign w_txd_wr  = wr_en & (addr == ADDR_TXD);
  assign w_con_wr  = wr_en & (addr == ADDR_CON);
  assign w_rxd_rd  = rd_en & (addr == ADDR_RXD);
  assign w_tx_busy = (r_state != TX_IDLE) | ~w_empty;
  assign w_unused  = ^wr_data[31:8];

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .i_clk   (sysclk),
    .i_srst  (reset),
    .i_push  (w_txd_wr),
    .i_data  (wr_data[7:0]),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // tx_s resets high so an idle sender is assumed until proven otherwise.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_tx_s1 <= 1'b1;
      r_tx_s2 <= 1'b1;
      r_rx_s1 <= 1'b0;
      r_rx_s2 <= 1'b0;
      r_rx_s3 <= 1'b0;
    end else begin
      r_tx_s1 <= uart_tx_status;
      r_tx_s2 <= r_tx_s1;
      r_rx_s1 <= uart_rx_status;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty && w_tx_s) begin
          w_pop        = 1'b1;
          w_state_next = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        if (!w_tx_s) begin
          w_state_next = TX_BUSY;
        end else if (r_to_cnt == TO_W'(START_TIMEOUT - 1)) begin
          w_state_next = TX_RETRY;
        end
      end
      TX_RETRY: w_state_next = TX_LAUNCH;
      TX_BUSY: begin
        if (w_tx_s) w_state_next = TX_IDLE;
      end
      default: w_state_next = TX_IDLE;
    endcase
  end

  // uart_tx_en is registered from the next state so the sender sees a clean level.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_to_cnt  <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_tx_en <= (w_state_next == TX_LAUNCH);
      if (w_pop) r_tx_data <= w_head;
      if (r_state == TX_LAUNCH && w_state_next == TX_LAUNCH) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  // A capture always beats a same-cycle read clear; sticky flags favour set over clear.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_buf    <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_tx_ovf    <= 1'b0;
      r_rx_irq_en <= 1'b0;
      r_tx_irq_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_rx_rise) r_rx_buf <= uart_rx_data;
      r_rx_valid <= w_rx_rise | (r_rx_valid & ~w_rxd_rd);
      r_rx_ovr   <= (w_rx_rise & r_rx_valid & ~w_rxd_rd) |
                    (r_rx_ovr & ~(w_con_wr & wr_data[CON_RX_OVR]));
      r_tx_ovf   <= (w_txd_wr & w_full) |
                    (r_tx_ovf & ~(w_con_wr & wr_data[CON_TX_OVF]));
      if (w_con_wr) begin
        r_rx_irq_en <= wr_data[CON_RX_IRQ_EN];
        r_tx_irq_en <= wr_data[CON_TX_IRQ_EN];
      end
      r_irq <= (r_rx_irq_en & r_rx_valid) | (r_tx_irq_en & ~w_tx_busy);
    end
  end

  always_comb begin
    w_con                          = '0;
    w_con[CON_TX_FULL]             = w_full;
    w_con[CON_TX_BUSY]             = w_tx_busy;
    w_con[CON_RX_VALID]            = r_rx_valid;
    w_con[CON_RX_OVR]              = r_rx_ovr;
    w_con[CON_TX_OVF]              = r_tx_ovf;
    w_con[CON_RX_IRQ_EN]           = r_rx_irq_en;
    w_con[CON_TX_IRQ_EN]           = r_tx_irq_en;
    w_con[CON_CNT_LSB +: CNT_W]    = w_count;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_TXD: rd_data = {24'b0, r_tx_data};
      ADDR_RXD: rd_data = {24'b0, r_rx_buf};
      ADDR_CON: rd_data = w_con;
      default:  rd_data = '0;
    endcase
  end

  assign irq          = r_irq;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;

endmodule
